// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver FSM states, default
// line parameters and the oversample divider calculation.
package uart_pkg;

  localparam int DEF_CLK_FREQ = 27_000_000;
  localparam int DEF_BAUD     = 9600;
  localparam int DEF_OVS      = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
    int den;
    den = baud * ovs;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; 'clear' realigns the phase so the
// next tick lands a full DIV clocks later. Shared by the UART rx and tx paths.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = calc_div(DEF_CLK_FREQ, DEF_BAUD, DEF_OVS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, glitch rejection on
// the start bit, framing-error reporting and a BREAK hold state.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD,
  parameter int OVS      = DEF_OVS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       framing_err,
  output logic       busy,
  output logic [2:0] o_dbg_state
);

  localparam int               DIV    = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int               TCW    = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [TCW-1:0]   T_MID  = TCW'(OVS / 2 - 1);
  localparam logic [TCW-1:0]   T_LAST = TCW'(OVS - 1);

  logic            r_sync1, r_sync2, r_rx_prev;
  uart_state_t     r_state, w_state_next;
  logic [TCW-1:0]  r_tick_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift, r_data;
  logic            r_data_ready, r_framing_err;

  logic w_tick, w_fall, w_div_clear;
  logic w_tick_clr, w_tick_inc, w_bit_clr, w_bit_inc;
  logic w_shift_en, w_load, w_ferr;

  // Two-flop synchronizer plus one history flop for edge detection; all
  // three idle high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_fall = r_rx_prev & ~r_sync2;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (w_div_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_div_clear  = 1'b0;
    w_tick_clr   = 1'b0;
    w_tick_inc   = 1'b0;
    w_bit_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_shift_en   = 1'b0;
    w_load       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
          w_div_clear  = 1'b1;
          w_tick_clr   = 1'b1;
          w_bit_clr    = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          if (r_tick_cnt == T_MID) begin
            w_tick_clr   = 1'b1;
            w_state_next = r_sync2 ? S_IDLE : S_DATA;
          end else begin
            w_tick_inc = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          if (r_tick_cnt == T_LAST) begin
            w_tick_clr = 1'b1;
            w_shift_en = 1'b1;
            w_bit_inc  = 1'b1;
            if (r_bit_cnt == 3'd7) w_state_next = S_STOP;
          end else begin
            w_tick_inc = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_tick_cnt == T_LAST) begin
            w_tick_clr = 1'b1;
            if (r_sync2) begin
              w_load       = 1'b1;
              w_state_next = S_IDLE;
            end else begin
              w_ferr       = 1'b1;
              w_state_next = S_BREAK;
            end
          end else begin
            w_tick_inc = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (r_sync2) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // data_ready/framing_err are registered, so each pulses one clk after the stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_data_ready  <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      if (w_tick_clr)      r_tick_cnt <= '0;
      else if (w_tick_inc) r_tick_cnt <= r_tick_cnt + 1'b1;
      if (w_bit_clr)       r_bit_cnt  <= '0;
      else if (w_bit_inc)  r_bit_cnt  <= r_bit_cnt + 1'b1;
      if (w_shift_en)      r_shift    <= {r_sync2, r_shift[7:1]};
      if (w_load)          r_data     <= r_shift;
      r_data_ready  <= w_load;
      r_framing_err <= w_ferr;
    end
  end

  assign data        = r_data;
  assign data_ready  = r_data_ready;
  assign framing_err = r_framing_err;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
